pma_region_unit: RTL
====================

Name: pma_region_unit

Overview:
- Runtime-programmable physical-memory-attribute (PMA) table. It replaces the fixed execute, cached and non-idempotent region lists that are currently frozen at elaboration.
- Holds NrRules address regions, each carrying exec/cached/nonidem attributes. Reset contents come from parameters.
- Serves NrPorts independent pipelined lookup channels (e.g. fetch, load/store) with valid/ready handshakes.
- Sits beside the PMP/MMU. Software programs it through a narrow configuration port driven by the CSR file.

Parameters:
- NrRules, 4, number of region entries (>=1).
- NrPorts, 2, number of lookup channels (>=1).
- AddrWidth, 64, physical address width.
- RstBase, '0, packed NrRules*AddrWidth reset base per entry (entry 0 in LSBs).
- RstLength, '0, packed NrRules*AddrWidth reset length per entry; 0 = entry disabled.
- RstAttr, '0, packed NrRules*3 reset attributes {exec,cached,nonidem}.
- DefaultAttr, 3'b000, attributes returned when no entry matches.

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  reset; asynchronous, active-low
- cfg_we_i  in  1  config write strobe
- cfg_re_i  in  1  config read strobe
- cfg_idx_i  in  $clog2(NrRules) (min 1)  entry index
- cfg_field_i  in  2  0=base, 1=length, 2=attr/lock, 3=reserved
- cfg_wdata_i  in  AddrWidth  write data; attr field uses [3:0] = {lock,exec,cached,nonidem}
- cfg_rdata_o  out  AddrWidth  registered read data
- cfg_err_o  out  1  one-cycle pulse: write rejected
- req_valid_i  in  NrPorts  lookup request valid
- req_ready_o  out  NrPorts  lookup request ready
- req_addr_i  in  NrPorts*AddrWidth  lookup addresses
- rsp_valid_o  out  NrPorts  response valid
- rsp_ready_i  in  NrPorts  response ready
- rsp_hit_o  out  NrPorts  some entry matched
- rsp_rule_o  out  NrPorts*$clog2(NrRules)  matching entry index (0 on miss)
- rsp_attr_o  out  NrPorts*3  {exec,cached,nonidem}

Behaviour:
- Reset:
  - Table loads RstBase/RstLength/RstAttr; all lock bits clear.
  - rsp_valid_o=0, rsp_hit_o=0, rsp_rule_o=0, rsp_attr_o=0.
  - cfg_rdata_o=0, cfg_err_o=0.
  - An asserted rst_ni drop mid-operation discards in-flight responses immediately.
- Match rule, per entry i:
  - length!=0 and base <= addr < base+length.
  - Evaluate the sum in AddrWidth+1 bits; no wrap-around, so regions crossing the top of the address space end at 2^AddrWidth.
- Priority: lowest matching index wins. On a miss: hit=0, rule=0, attr=DefaultAttr.
- Lookup pipeline, each port independent, one register stage:
  - Latency is exactly 1 cycle.
  - req_ready_o[p] = !rsp_valid_o[p] || rsp_ready_i[p].
  - A transfer (valid & ready) loads the response register and sets rsp_valid_o.
  - rsp_valid_o clears on rsp_ready_i without a new transfer.
  - While stalled (valid & !ready), the response holds stable, including across table writes.
- Config write:
  - Takes effect at the clock edge, so a lookup accepted in the same cycle sees the old table.
  - Attr write with wdata[3]=1 sets lock.
  - Any write to a locked entry is ignored and pulses cfg_err_o the next cycle.
  - A field=3 write is ignored and pulses cfg_err_o.
  - Locks clear only on reset.
- Config read:
  - cfg_rdata_o is updated the cycle after cfg_re_i: base, length, or zero-extended {lock,attr}; field 3 returns 0.
  - Holds its value otherwise.
  - Simultaneous cfg_we_i and cfg_re_i to the same entry/field returns the old value.
- cfg_idx_i >= NrRules (non-power-of-two NrRules): write ignored with cfg_err_o pulse; read returns 0.

Decomposition:
- Shared package pma_pkg:
  - pma_attr_t packed struct {lock, exec, cached, nonidem}.
  - pma_field_e enum (BASE, LENGTH, ATTR, RSVD).
  - pma_rule_t struct {base, length, attr}.
  - ATTR_W=3 constant.
- One sub-module, pma_region_match: combinational per-port comparator and priority encoder over the rule array, instantiated NrPorts times. The top module holds the table, config logic and response registers.

Test Plan:
- Program entry0 base=0x8000_0000, length=0x4000_0000, attr=exec|cached; lookup port0 addr 0x8000_1000 -> next cycle rsp_valid=1, hit=1, rule=0, attr=3'b110; addr 0xC000_0000 -> hit=0, attr=DefaultAttr.
- Entry0 0x1000/0x1000 attr nonidem, entry1 0x0/0x10000 attr exec; addr 0x1800 -> rule=0, attr=3'b001; addr 0x2000 -> rule=1, attr=3'b100.
- Entry2 base=0xFFFF_FFFF_FFFF_F000, length=0x2000; addr 0xFFFF_FFFF_FFFF_FFF0 -> hit, rule=2; addr 0x10 -> miss (no wrap).
- Write attr=0x8|exec to entry1, then base=0x5000 -> cfg_err_o pulses 1 cycle; read base -> previous value; after reset, lock clear and parameter values restored.
- Port1 rsp_ready_i=0 for 3 cycles with req_valid held -> req_ready_o=0, response stable while entry0 is rewritten; after release the response holds old attr, and the next request sees the new attr.
- Both ports issue in the same cycle as a cfg write to the matching entry -> both responses reflect the pre-write table.

Source files
------------

// File: rtl/pma_pkg.sv
// Shared types and constants for the physical-memory-attribute region unit.
package pma_pkg;

    // Number of attribute bits returned per lookup: {exec, cached, nonidem}.
    localparam int unsigned ATTR_W = 3;

    // Widest physical address any instance is expected to use.
    localparam int unsigned MaxAddrWidth = 64;

    // Stored per-entry attribute word; lock sits above the three returned attributes.
    typedef struct packed {
        logic lock;
        logic exec;
        logic cached;
        logic nonidem;
    } pma_attr_t;

    // Field selector on the configuration port.
    typedef enum logic [1:0] {
        FieldBase   = 2'd0,
        FieldLength = 2'd1,
        FieldAttr   = 2'd2,
        FieldRsvd   = 2'd3
    } pma_field_e;

    // One region entry at the widest supported address width.
    typedef struct packed {
        logic [MaxAddrWidth-1:0] base;
        logic [MaxAddrWidth-1:0] length;
        pma_attr_t               attr;
    } pma_rule_t;

    // Strip the lock bit, leaving the attributes a lookup returns.
    function automatic logic [ATTR_W-1:0] attr_bits(input pma_attr_t a);
        return {a.exec, a.cached, a.nonidem};
    endfunction

endpackage

// File: rtl/pma_region_match.sv
// Combinational region comparator and lowest-index priority encoder for one lookup port.
module pma_region_match
    import pma_pkg::*;
#(
    parameter int unsigned       NrRules     = 4,
    parameter int unsigned       AddrWidth   = 64,
    parameter logic [ATTR_W-1:0] DefaultAttr = 3'b000,
    localparam int unsigned      IdxW        = (NrRules > 1) ? $clog2(NrRules) : 1
) (
    input  logic [AddrWidth-1:0]         addr_i,
    input  logic [NrRules*AddrWidth-1:0] base_i,
    input  logic [NrRules*AddrWidth-1:0] length_i,
    input  logic [NrRules*ATTR_W-1:0]    attr_i,
    output logic                         hit_o,
    output logic [IdxW-1:0]              rule_o,
    output logic [ATTR_W-1:0]            attr_o
);

    logic [NrRules-1:0] w_match;

    for (genvar g = 0; g < NrRules; g++) begin : g_rule
        logic [AddrWidth-1:0] w_base;
        logic [AddrWidth-1:0] w_len;
        logic [AddrWidth:0]   w_end;

        assign w_base = base_i[g*AddrWidth +: AddrWidth];
        assign w_len  = length_i[g*AddrWidth +: AddrWidth];
        // One extra bit keeps regions that run past the top of memory from wrapping to zero.
        assign w_end  = {1'b0, w_base} + {1'b0, w_len};
        assign w_match[g] = (w_len != '0) && (addr_i >= w_base) && ({1'b0, addr_i} < w_end);
    end

    // Scan from the highest index down so the lowest matching entry is the last to win.
    always_comb begin
        hit_o  = 1'b0;
        rule_o = '0;
        attr_o = DefaultAttr;
        for (int i = NrRules - 1; i >= 0; i--) begin
            if (w_match[i]) begin
                hit_o  = 1'b1;
                rule_o = IdxW'(i);
                attr_o = attr_i[i*ATTR_W +: ATTR_W];
            end
        end
    end

endmodule

// File: rtl/pma_region_unit.sv
// Runtime-programmable PMA table: region storage, CSR-side config port and one registered
// lookup stage per port with valid/ready handshakes on both sides.
module pma_region_unit
    import pma_pkg::*;
#(
    parameter int unsigned                  NrRules     = 4,
    parameter int unsigned                  NrPorts     = 2,
    parameter int unsigned                  AddrWidth   = 64,
    parameter logic [NrRules*AddrWidth-1:0] RstBase     = '0,
    parameter logic [NrRules*AddrWidth-1:0] RstLength   = '0,
    parameter logic [NrRules*ATTR_W-1:0]    RstAttr     = '0,
    parameter logic [ATTR_W-1:0]            DefaultAttr = 3'b000,
    localparam int unsigned                 IdxW        = (NrRules > 1) ? $clog2(NrRules) : 1
) (
    input  logic                         clk_i,
    input  logic                         rst_ni,
    input  logic                         cfg_we_i,
    input  logic                         cfg_re_i,
    input  logic [IdxW-1:0]              cfg_idx_i,
    input  logic [1:0]                   cfg_field_i,
    input  logic [AddrWidth-1:0]         cfg_wdata_i,
    output logic [AddrWidth-1:0]         cfg_rdata_o,
    output logic                         cfg_err_o,
    input  logic [NrPorts-1:0]           req_valid_i,
    output logic [NrPorts-1:0]           req_ready_o,
    input  logic [NrPorts*AddrWidth-1:0] req_addr_i,
    output logic [NrPorts-1:0]           rsp_valid_o,
    input  logic [NrPorts-1:0]           rsp_ready_i,
    output logic [NrPorts-1:0]           rsp_hit_o,
    output logic [NrPorts*IdxW-1:0]      rsp_rule_o,
    output logic [NrPorts*ATTR_W-1:0]    rsp_attr_o
);

    // Region table.
    logic [AddrWidth-1:0] r_base   [NrRules];
    logic [AddrWidth-1:0] r_length [NrRules];
    pma_attr_t            r_attr   [NrRules];

    // Config-port state.
    logic [AddrWidth-1:0] r_cfg_rdata;
    logic                 r_cfg_err;

    // Config decode.
    logic [31:0]          w_idx_ext;
    logic                 w_idx_ok;
    pma_field_e           w_field;
    logic [AddrWidth-1:0] w_sel_base;
    logic [AddrWidth-1:0] w_sel_length;
    pma_attr_t            w_sel_attr;
    logic [3:0]           w_sel_attr_bits;
    logic                 w_wr_err;
    logic                 w_wr_en;
    logic [AddrWidth-1:0] w_rd_data;

    // Flattened table seen by every lookup port.
    logic [NrRules*AddrWidth-1:0] w_base_flat;
    logic [NrRules*AddrWidth-1:0] w_length_flat;
    logic [NrRules*ATTR_W-1:0]    w_attr_flat;

    // Indices past NrRules only exist when NrRules is not a power of two.
    assign w_idx_ext = 32'(cfg_idx_i);
    assign w_idx_ok  = (w_idx_ext < NrRules);
    assign w_field   = pma_field_e'(cfg_field_i);

    // Select the addressed entry; an out-of-range index reads as all zeros.
    always_comb begin
        w_sel_base   = '0;
        w_sel_length = '0;
        w_sel_attr   = '0;
        for (int i = 0; i < NrRules; i++) begin
            if (cfg_idx_i == IdxW'(i)) begin
                w_sel_base   = r_base[i];
                w_sel_length = r_length[i];
                w_sel_attr   = r_attr[i];
            end
        end
    end

    assign w_sel_attr_bits = w_sel_attr;

    // Locked entries, the reserved field and nonexistent entries all refuse writes.
    assign w_wr_err = cfg_we_i && (!w_idx_ok || (w_field == FieldRsvd) || w_sel_attr.lock);
    assign w_wr_en  = cfg_we_i && !w_wr_err;

    // Read mux; reads the pre-write table, so a same-cycle write is not visible.
    always_comb begin
        w_rd_data = '0;
        if (w_idx_ok) begin
            unique case (w_field)
                FieldBase:   w_rd_data = w_sel_base;
                FieldLength: w_rd_data = w_sel_length;
                FieldAttr:   w_rd_data = AddrWidth'(w_sel_attr_bits);
                default:     w_rd_data = '0;
            endcase
        end
    end

    // Table storage: reset image from parameters, then accepted config writes.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < NrRules; i++) begin
                r_base[i]   <= RstBase[i*AddrWidth +: AddrWidth];
                r_length[i] <= RstLength[i*AddrWidth +: AddrWidth];
                r_attr[i]   <= {1'b0, RstAttr[i*ATTR_W +: ATTR_W]};
            end
        end else if (w_wr_en) begin
            for (int i = 0; i < NrRules; i++) begin
                if (cfg_idx_i == IdxW'(i)) begin
                    unique case (w_field)
                        FieldBase:   r_base[i]   <= cfg_wdata_i;
                        FieldLength: r_length[i] <= cfg_wdata_i;
                        FieldAttr:   r_attr[i]   <= pma_attr_t'(cfg_wdata_i[3:0]);
                        default:     ;
                    endcase
                end
            end
        end
    end

    // Config response: read data holds between reads; error is a single-cycle pulse.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_cfg_rdata <= '0;
            r_cfg_err   <= 1'b0;
        end else begin
            r_cfg_err <= w_wr_err;
            if (cfg_re_i) begin
                r_cfg_rdata <= w_rd_data;
            end
        end
    end

    assign cfg_rdata_o = r_cfg_rdata;
    assign cfg_err_o   = r_cfg_err;

    // Pack the table for the per-port comparators (lock bit is not a lookup attribute).
    always_comb begin
        w_base_flat   = '0;
        w_length_flat = '0;
        w_attr_flat   = '0;
        for (int i = 0; i < NrRules; i++) begin
            w_base_flat[i*AddrWidth +: AddrWidth]   = r_base[i];
            w_length_flat[i*AddrWidth +: AddrWidth] = r_length[i];
            w_attr_flat[i*ATTR_W +: ATTR_W]         = attr_bits(r_attr[i]);
        end
    end

    for (genvar p = 0; p < NrPorts; p++) begin : g_port
        logic              w_hit;
        logic [IdxW-1:0]   w_rule;
        logic [ATTR_W-1:0] w_attr;
        logic              w_xfer;
        logic              r_valid;
        logic              r_hit;
        logic [IdxW-1:0]   r_rule;
        logic [ATTR_W-1:0] r_attr_q;

        pma_region_match #(
            .NrRules     (NrRules),
            .AddrWidth   (AddrWidth),
            .DefaultAttr (DefaultAttr)
        ) u_match (
            .addr_i   (req_addr_i[p*AddrWidth +: AddrWidth]),
            .base_i   (w_base_flat),
            .length_i (w_length_flat),
            .attr_i   (w_attr_flat),
            .hit_o    (w_hit),
            .rule_o   (w_rule),
            .attr_o   (w_attr)
        );

        assign req_ready_o[p] = !r_valid || rsp_ready_i[p];
        assign w_xfer         = req_valid_i[p] && req_ready_o[p];

        // Response register: load on accept, drop on consume, otherwise hold (stall).
        always_ff @(posedge clk_i or negedge rst_ni) begin
            if (!rst_ni) begin
                r_valid  <= 1'b0;
                r_hit    <= 1'b0;
                r_rule   <= '0;
                r_attr_q <= '0;
            end else if (w_xfer) begin
                r_valid  <= 1'b1;
                r_hit    <= w_hit;
                r_rule   <= w_rule;
                r_attr_q <= w_attr;
            end else if (rsp_ready_i[p]) begin
                r_valid  <= 1'b0;
            end
        end

        assign rsp_valid_o[p]                = r_valid;
        assign rsp_hit_o[p]                  = r_hit;
        assign rsp_rule_o[p*IdxW +: IdxW]    = r_rule;
        assign rsp_attr_o[p*ATTR_W +: ATTR_W] = r_attr_q;
    end

endmodule
